// File: rtl/two_bit_inc_core.sv
// 2-bit accumulator leaf: 4x2 instruction RAM read at an externally sequenced
// address, ripple incrementer, accumulator and sticky overflow flag.
module two_bit_inc_core #(
   parameter logic [7:0] INIT_PROG = 8'b0000_0000,
   parameter int         DATA_W    = 2
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [1:0]        addr,
   input  logic              ram_we,
   input  logic [1:0]        ram_waddr,
   input  logic [DATA_W-1:0] ram_wdata,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] acc,
   output logic              status
);

   if (DATA_W != 2) begin : g_bad_width
      $error("two_bit_inc_core only supports DATA_W == 2");
   end

   localparam logic [DATA_W-1:0] OP_INC = '0;

   logic [DATA_W-1:0] mem [4];
   logic [DATA_W-1:0] acc_inc;
   logic              carry;
   logic              is_inc;
   logic              c0;
   logic              s0;
   logic              s1;

   // One full-adder cell; returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
      return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
   endfunction

   // Instruction fetch is a pure combinational RAM read.
   assign instr  = mem[addr];
   assign is_inc = (instr == OP_INC);

   // Ripple incrementer: constant addend 01, carry-in 0; carry-out only feeds status.
   always_comb begin
      {c0, s0}     = full_add(acc[0], 1'b1, 1'b0);
      {carry, s1}  = full_add(acc[1], 1'b0, c0);
      acc_inc      = {s1, s0};
   end

   // RAM: reset reloads the program and masks any simultaneous write.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            mem[k] <= INIT_PROG[2*k +: DATA_W];
         end
      end else if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
   end

   // Execute uses the pre-edge instr, so a same-address write is seen next cycle.
   // An unknown instr compares as X and falls through to hold.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         acc    <= '0;
         status <= 1'b0;
      end else if (is_inc) begin
         acc    <= acc_inc;
         status <= status | carry;
      end
   end

endmodule

// File: tb/tb_two_bit_inc_core.sv
// Bench for two_bit_inc_core: directed plan plus random traffic against an
// arithmetic reference model of the RAM, accumulator and sticky flag.
module tb_two_bit_inc_core;

   localparam logic [7:0] PROG = 8'b01_10_00_00;

   logic       clock;
   logic       rst_n;
   logic [1:0] addr;
   logic       ram_we;
   logic [1:0] ram_waddr;
   logic [1:0] ram_wdata;
   logic [1:0] instr;
   logic [1:0] acc;
   logic       status;

   int checks;
   int errors;

   int   m_mem [4];
   int   m_acc;
   logic m_status;

   two_bit_inc_core #(
      .INIT_PROG(PROG),
      .DATA_W   (2)
   ) dut (
      .clock    (clock),
      .rst_n    (rst_n),
      .addr     (addr),
      .ram_we   (ram_we),
      .ram_waddr(ram_waddr),
      .ram_wdata(ram_wdata),
      .instr    (instr),
      .acc      (acc),
      .status   (status)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_mem[k] = (PROG >> (2 * k)) & 3;
      m_acc    = 0;
      m_status = 1'b0;
   endtask

   // Drive one cycle of inputs, check the combinational read, clock, check state.
   task automatic step(input logic r, input logic [1:0] a, input logic we,
                       input logic [1:0] wa, input logic [1:0] wd, input string tag);
      int old_word;
      @(negedge clock);
      rst_n = r; addr = a; ram_we = we; ram_waddr = wa; ram_wdata = wd;
      #1;
      chk({tag, ":instr_pre"}, instr, 2'(m_mem[a]));
      old_word = m_mem[a];
      @(posedge clock);
      if (!r) begin
         model_reset();
      end else begin
         if (old_word == 0) begin
            if (m_acc + 1 == 4) m_status = 1'b1;
            m_acc = (m_acc + 1) % 4;
         end
         if (we) m_mem[wa] = wd;
      end
      #1;
      chk({tag, ":acc"}, acc, 2'(m_acc));
      chk({tag, ":status"}, {1'b0, status}, {1'b0, m_status});
      chk({tag, ":instr_post"}, instr, 2'(m_mem[a]));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; addr = 2'b00; ram_we = 1'b0; ram_waddr = 2'b00; ram_wdata = 2'b00;
      model_reset();

      // Reset for two edges, then INC from word 0 through two wraps.
      @(posedge clock);
      @(posedge clock);
      #1;
      chk("reset_acc", acc, 2'b00);
      chk("reset_status", {1'b0, status}, 2'b00);
      for (int i = 0; i < 8; i++) step(1'b1, 2'b00, 1'b0, 2'b00, 2'b00, "inc_run");
      chk("after_two_wraps_acc", acc, 2'b00);
      chk("after_two_wraps_status", {1'b0, status}, 2'b01);

      // Non-INC hold at word 3 (01), then resume INC at word 0.
      step(1'b1, 2'b00, 1'b0, 2'b00, 2'b00, "pre_hold");
      step(1'b1, 2'b00, 1'b0, 2'b00, 2'b00, "pre_hold");
      for (int i = 0; i < 5; i++) step(1'b1, 2'b11, 1'b0, 2'b00, 2'b00, "hold");
      chk("hold_acc", acc, 2'b10);
      step(1'b1, 2'b00, 1'b0, 2'b00, 2'b00, "resume");
      chk("resume_acc", acc, 2'b11);

      // Read-during-write: old INC executes, new word visible afterwards.
      step(1'b1, 2'b00, 1'b1, 2'b00, 2'b10, "rdw");
      chk("rdw_acc", acc, 2'b00);
      chk("rdw_instr", instr, 2'b10);
      step(1'b1, 2'b00, 1'b0, 2'b00, 2'b00, "rdw_hold");
      chk("rdw_hold_acc", acc, 2'b00);

      // Mid-run reset with a colliding write on an INC word.
      step(1'b1, 2'b01, 1'b0, 2'b00, 2'b00, "pre_rst");
      step(1'b1, 2'b01, 1'b0, 2'b00, 2'b00, "pre_rst");
      step(1'b0, 2'b01, 1'b1, 2'b01, 2'b11, "midrst");
      chk("midrst_acc", acc, 2'b00);
      chk("midrst_status", {1'b0, status}, 2'b00);
      chk("midrst_instr", instr, 2'b00);
      step(1'b1, 2'b10, 1'b0, 2'b00, 2'b00, "reload2");
      chk("reload2_instr", instr, 2'b10);

      // Address switch: INC, hold, INC.
      for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 1'b0, 2'b00, 2'b00, "sw_a0");
      for (int i = 0; i < 5; i++) step(1'b1, 2'b10, 1'b0, 2'b00, 2'b00, "sw_a2");
      for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b0, 2'b00, 2'b00, "sw_a1");
      chk("switch_end_acc", acc, 2'b10);

      // Random traffic with occasional writes and resets.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 39) != 0), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
